// File: rtl/lsu_stb_pkg.sv
// Shared constants and types for the store-buffer drain controller.
package lsu_stb_pkg;
    localparam int STB_ENTRIES = 8;
    localparam int STB_PTR_W   = 3;
    localparam int SI_W        = 2;
    localparam int RTYPE_W     = 2;

    // Drain FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Per-entry state carried with a PCX store request
    typedef struct packed {
        logic [SI_W-1:0]    si;
        logic [RTYPE_W-1:0] rtype;
        logic               rmo;
    } stb_fields_t;
endpackage

// File: rtl/lsu_stb_entry_mux.sv
// Selects the captured si/rtype/rmo state of one store-buffer entry.
module lsu_stb_entry_mux
    import lsu_stb_pkg::*;
(
    input  logic [STB_PTR_W-1:0]           ptr,
    input  logic [STB_ENTRIES*SI_W-1:0]    si,
    input  logic [STB_ENTRIES*RTYPE_W-1:0] rtype,
    input  logic [STB_ENTRIES-1:0]         rmo,
    output stb_fields_t                    fields
);
    // 8:1 field select by entry index
    always_comb begin
        fields.si    = si[ptr*SI_W +: SI_W];
        fields.rtype = rtype[ptr*RTYPE_W +: RTYPE_W];
        fields.rmo   = rmo[ptr];
    end
endmodule

// File: rtl/lsu_stb_drain_ctl.sv
// Store-buffer read side: issues entries in FIFO order to the PCX under TSO/RMO
// rules, tracks outstanding stores and retires them in order on CPX acks.
module lsu_stb_drain_ctl
    import lsu_stb_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                           rclk,
    input  logic                           arst_l,
    input  logic [STB_ENTRIES-1:0]         stb_vld,
    input  logic [STB_ENTRIES*SI_W-1:0]    stb_state_si,
    input  logic [STB_ENTRIES*RTYPE_W-1:0] stb_state_rtype,
    input  logic [STB_ENTRIES-1:0]         stb_state_rmo,
    input  logic                           pcx_grant,
    input  logic                           cpx_st_ack,
    input  logic                           drain_stall,
    output logic                           pcx_req,
    output logic [STB_PTR_W-1:0]           pcx_req_ptr,
    output logic [SI_W-1:0]                pcx_req_si,
    output logic [RTYPE_W-1:0]             pcx_req_rtype,
    output logic                           pcx_req_rmo,
    output logic [STB_ENTRIES-1:0]         stb_ack_clr,
    output logic [3:0]                     stb_out_cnt,
    output logic                           stb_drained,
    output logic                           stb_ack_err
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    logic [0:0]           state;
    logic [STB_PTR_W-1:0] iss_ptr;
    logic [STB_PTR_W-1:0] ack_ptr;
    logic [3:0]           cnt;
    logic                 tso_block;
    stb_fields_t          sel;
    stb_fields_t          req_q;
    logic                 eligible;
    logic                 grant_fire;
    logic                 ack_ok;
    logic [3:0]           cnt_nxt;

    lsu_stb_entry_mux u_mux (
        .ptr    (iss_ptr),
        .si     (stb_state_si),
        .rtype  (stb_state_rtype),
        .rmo    (stb_state_rmo),
        .fields (sel)
    );

    // Issue eligibility and outstanding-count update
    always_comb begin
        grant_fire = (state == ST_REQ) & pcx_grant;
        ack_ok     = cpx_st_ack & (cnt != 4'd0);
        eligible   = (state == ST_IDLE) & stb_vld[iss_ptr] & ~drain_stall & ~tso_block
                   & (cnt < MAX_CNT) & (sel.rmo | (cnt == 4'd0));
        cnt_nxt    = cnt + {3'd0, grant_fire} - {3'd0, ack_ok};
    end

    // Request FSM; fields are frozen at REQ entry so they stay stable until grant
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state <= ST_IDLE;
            req_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (eligible) begin
                    state <= ST_REQ;
                    req_q <= sel;
                end
                default: if (pcx_grant) state <= ST_IDLE;
            endcase
        end
    end

    // Issue/retire pointers and outstanding count
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            iss_ptr <= '0;
            ack_ptr <= '0;
            cnt     <= '0;
        end else begin
            if (grant_fire) iss_ptr <= iss_ptr + 3'd1;
            if (ack_ok)     ack_ptr <= ack_ptr + 3'd1;
            cnt <= cnt_nxt;
        end
    end

    // A granted non-RMO store holds off issue until everything has drained
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l)                         tso_block <= 1'b0;
        else if (grant_fire && !req_q.rmo)   tso_block <= 1'b1;
        else if (ack_ok && cnt_nxt == 4'd0)  tso_block <= 1'b0;
    end

    // Retire strobe one cycle after the ack; sticky flag for acks with nothing outstanding
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            stb_ack_clr <= '0;
            stb_ack_err <= 1'b0;
        end else begin
            stb_ack_clr <= ack_ok ? (8'b1 << ack_ptr) : 8'b0;
            if (cpx_st_ack && cnt == 4'd0) stb_ack_err <= 1'b1;
        end
    end

    assign pcx_req       = (state == ST_REQ);
    assign pcx_req_ptr   = iss_ptr;
    assign pcx_req_si    = req_q.si;
    assign pcx_req_rtype = req_q.rtype;
    assign pcx_req_rmo   = req_q.rmo;
    assign stb_out_cnt   = cnt;
    assign stb_drained   = ~|stb_vld & (cnt == 4'd0);
endmodule

// File: doc/lsu_stb_drain_ctl.md
Name: lsu_stb_drain_ctl

Overview:
- Read-side controller for the 8-entry per-thread store buffer.
- Walks entries in FIFO order and presents the oldest unissued valid entry to the PCX as a store request, carrying the captured per-entry state (va[7:6] set index, rq_type[2:1], rmo).
- Tracks issued-but-unacked stores and retires entries in order on CPX store acks, producing one-hot clear strobes back to the store buffer.
- Enforces TSO: a non-RMO store issues only with zero outstanding and blocks further issue until acked. RMO stores pipeline up to MAX_OUT.

Parameters:
MAX_OUT, 4, max outstanding issued-unacked stores; legal range 1..8.

Ports:
rclk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
stb_vld  in  8  per-entry valid from store buffer write side
stb_state_si  in  16  entry i bits [2i+1:2i] = va[7:6]
stb_state_rtype  in  16  entry i bits [2i+1:2i] = rq_type[2:1]
stb_state_rmo  in  8  per-entry rmo bit
pcx_grant  in  1  PCX accepts current request this cycle
cpx_st_ack  in  1  one store ack, in issue order
drain_stall  in  1  hold off new request launch (trap/flush)
pcx_req  out  1  store request valid
pcx_req_ptr  out  3  entry index being requested
pcx_req_si  out  2  va[7:6] of requested entry
pcx_req_rtype  out  2  rq_type of requested entry
pcx_req_rmo  out  1  rmo of requested entry
stb_ack_clr  out  8  one-hot retire strobe, 1 cycle
stb_out_cnt  out  4  issued-unacked count
stb_drained  out  1  no valid entries and stb_out_cnt==0
stb_ack_err  out  1  sticky: ack received with stb_out_cnt==0

Behaviour:
- Reset (async, arst_l=0): iss_ptr=0, ack_ptr=0, cnt=0, tso_block=0, FSM=IDLE, stb_ack_err=0. Outputs pcx_req=0, stb_ack_clr=0, pcx_req_* fields=0. stb_drained is combinational from stb_vld and cnt. Reset mid-request drops pcx_req immediately; no grant is honoured.
- FSM states:
  - IDLE: go to REQ next cycle when eligible = stb_vld[iss_ptr] & ~drain_stall & ~tso_block & cnt<MAX_OUT & (rmo[iss_ptr] | cnt==0).
  - REQ: pcx_req=1. pcx_req_* are registered at REQ entry from entry iss_ptr and held stable until grant. drain_stall does not withdraw an asserted request.
  - On pcx_grant in REQ: iss_ptr++ (mod 8, wraps 7->0), cnt++. If the store is non-RMO, set tso_block. Return to IDLE. Latency from eligible to first pcx_req is 1 cycle. Back-to-back RMO issue therefore takes 2 cycles per store.
- Ack path:
  - cpx_st_ack: stb_ack_clr = onehot(ack_ptr), registered, asserted the cycle after the ack. ack_ptr++ (wraps), cnt--.
  - tso_block clears when cnt reaches 0 through an ack.
- Ack with cnt==0: no pointer or count change, no clear strobe, stb_ack_err=1 (sticky until reset).
- Simultaneous grant and ack: cnt unchanged; both pointers advance.
- Counter limits: cnt never exceeds MAX_OUT. iss_ptr never passes ack_ptr by more than MAX_OUT.
- Entry validity: stb_vld[iss_ptr] dropping while in REQ is illegal upstream. Bench asserts against it; RTL does not check.
- stb_drained = ~|stb_vld & (cnt==0).

Decomposition:
- Shared package lsu_stb_pkg: STB_ENTRIES=8, STB_PTR_W=3, FSM state encodings (IDLE=1'b0, REQ=1'b1), field width constants (SI_W=2, RTYPE_W=2).
- One natural sub-module: lsu_stb_entry_mux, the 8:1 mux of si/rtype/rmo indexed by pointer. All remaining logic stays flat.

Test Plan:
- Single TSO store: stb_vld=0x01, rmo=0, grant 2 cycles after pcx_req rises. Required: pcx_req_ptr=0 held until grant, cnt=1, no further req. Ack gives stb_ack_clr=0x01 one cycle later, cnt=0, stb_drained=1 once vld clears.
- RMO pipelining: entries 0..5 valid, all rmo=1, grant every REQ, no acks. Required: exactly 4 grants (ptr 0..3), cnt=4, pcx_req stays 0. One ack resumes issue of ptr 4.
- TSO after RMO: entry0 rmo=1, entry1 rmo=0. Required: entry1 not requested until entry0 acked (cnt=0). Entry2 not requested until entry1 acked.
- Wrap-around: start with pointers at 6 and entries 6,7,0 valid (RMO). Required: pcx_req_ptr sequence 6,7,0; ack clears 0x40, 0x80, 0x01.
- Simultaneous grant and ack with cnt=2: required cnt stays 2, iss_ptr and ack_ptr both +1. Spurious ack with cnt=0: stb_ack_err=1, stb_ack_clr=0.
- Reset in REQ: assert arst_l=0 while pcx_req=1 and grant pulses. Required: pcx_req=0 immediately; after release iss_ptr=0, cnt=0, stb_ack_err=0.
